// File: rtl/muldiv_iterative_unit_pkg.sv
// Shared mul/div operation encoding and small arithmetic helpers.
// The decode stage's control table uses the same muldiv_funct_t.
package selector;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_MADD  = 4'd3,
    MD_MADDU = 4'd4,
    MD_MSUB  = 4'd5,
    MD_MSUBU = 4'd6,
    MD_DIV   = 4'd7,
    MD_DIVU  = 4'd8
  } muldiv_funct_t;

  function automatic logic md_is_signed(input muldiv_funct_t f);
    case (f)
      MD_MULT, MD_MADD, MD_MSUB, MD_DIV: return 1'b1;
      default:                           return 1'b0;
    endcase
  endfunction

  function automatic logic md_is_div(input muldiv_funct_t f);
    case (f)
      MD_DIV, MD_DIVU: return 1'b1;
      default:         return 1'b0;
    endcase
  endfunction

  function automatic logic md_is_acc_add(input muldiv_funct_t f);
    case (f)
      MD_MADD, MD_MADDU: return 1'b1;
      default:           return 1'b0;
    endcase
  endfunction

  function automatic logic md_is_acc_sub(input muldiv_funct_t f);
    case (f)
      MD_MSUB, MD_MSUBU: return 1'b1;
      default:           return 1'b0;
    endcase
  endfunction

  // Magnitude of a signed word; 32'h8000_0000 yields unsigned 2^31.
  function automatic logic [31:0] md_abs(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [31:0] md_neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  function automatic logic [63:0] md_neg64(input logic [63:0] v);
    return ~v + 64'd1;
  endfunction

endpackage

// File: rtl/muldiv_iterative_unit_sign_fixup.sv
// Final sign correction and accumulate step applied to the raw magnitude result.
// Multiply: raw is the 64-bit product. Divide: raw is {remainder, quotient}.
module muldiv_sign_fixup
  import selector::*;
(
  input  muldiv_funct_t funct,
  input  logic [63:0]   raw,
  input  logic          sign_a,
  input  logic          sign_b,
  input  logic          div_zero,
  input  logic [63:0]   acc,
  output logic [31:0]   hi,
  output logic [31:0]   lo
);

  logic        neg_s;
  logic [63:0] prod_s;
  logic [63:0] res_s;
  logic [31:0] quo_s;
  logic [31:0] rem_s;

  // Sign application and 64-bit wrap-around accumulate.
  always_comb begin
    neg_s  = md_is_signed(funct) & (sign_a ^ sign_b);
    prod_s = neg_s ? md_neg64(raw) : raw;
    quo_s  = 32'd0;
    rem_s  = 32'd0;
    res_s  = prod_s;
    if (md_is_div(funct)) begin
      // Zero divisor: the quotient is all ones regardless of operand signs.
      if (div_zero) begin
        quo_s = 32'hFFFF_FFFF;
      end else if (neg_s) begin
        quo_s = md_neg32(raw[31:0]);
      end else begin
        quo_s = raw[31:0];
      end
      if (md_is_signed(funct) && sign_a) begin
        rem_s = md_neg32(raw[63:32]);
      end else begin
        rem_s = raw[63:32];
      end
      res_s = {rem_s, quo_s};
    end else if (md_is_acc_add(funct)) begin
      res_s = acc + prod_s;
    end else if (md_is_acc_sub(funct)) begin
      res_s = acc - prod_s;
    end else begin
      res_s = prod_s;
    end
    hi = res_s[63:32];
    lo = res_s[31:0];
  end

endmodule

// File: rtl/muldiv_iterative_unit.sv
// Iterative HI/LO multiply/divide unit: 32 radix-2 steps plus one fixup cycle.
// The result is held in DONE until the execute stage consumes it.
module muldiv_iterative_unit
  import selector::*;
#(
  parameter int ITER_BITS = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  muldiv_funct_t funct,
  input  logic [31:0]   rs,
  input  logic [31:0]   rt,
  input  logic [31:0]   hi_in,
  input  logic [31:0]   lo_in,
  input  logic          clear,
  input  logic          hold_result,
  output logic          busy,
  output logic          done,
  output logic [31:0]   hi_out,
  output logic [31:0]   lo_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t               state_r;
  logic [ITER_BITS-1:0] count_r;
  logic [63:0]          work_r;
  logic [31:0]          opnd_r;
  logic [63:0]          acc_r;
  muldiv_funct_t        funct_r;
  logic                 sign_a_r;
  logic                 sign_b_r;
  logic                 div_zero_r;
  logic                 busy_r;
  logic                 done_r;
  logic [31:0]          hi_r;
  logic [31:0]          lo_r;

  logic [31:0] rs_mag_s;
  logic [31:0] rt_mag_s;
  logic [32:0] mul_sum_s;
  logic [32:0] div_shift_s;
  logic [32:0] div_diff_s;
  logic [63:0] step_s;
  logic [31:0] fix_hi_s;
  logic [31:0] fix_lo_s;

  // Operand magnitudes for the request being presented.
  always_comb begin
    if (md_is_signed(funct)) begin
      rs_mag_s = md_abs(rs);
      rt_mag_s = md_abs(rt);
    end else begin
      rs_mag_s = rs;
      rt_mag_s = rt;
    end
  end

  // One radix-2 step; work_r is {hi,lo} of the product or {remainder,quotient}.
  always_comb begin
    mul_sum_s   = {1'b0, work_r[63:32]} + {1'b0, (work_r[0] ? opnd_r : 32'd0)};
    div_shift_s = {work_r[63:32], work_r[31]};
    div_diff_s  = div_shift_s - {1'b0, opnd_r};
    if (md_is_div(funct_r)) begin
      if (div_diff_s[32]) begin
        step_s = {div_shift_s[31:0], work_r[30:0], 1'b0};
      end else begin
        step_s = {div_diff_s[31:0], work_r[30:0], 1'b1};
      end
    end else begin
      step_s = {mul_sum_s, work_r[31:1]};
    end
  end

  muldiv_sign_fixup u_fixup (
    .funct    (funct_r),
    .raw      (work_r),
    .sign_a   (sign_a_r),
    .sign_b   (sign_b_r),
    .div_zero (div_zero_r),
    .acc      (acc_r),
    .hi       (fix_hi_s),
    .lo       (fix_lo_s)
  );

  // Sequencing FSM with registered status and result outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      count_r    <= '0;
      work_r     <= 64'd0;
      opnd_r     <= 32'd0;
      acc_r      <= 64'd0;
      funct_r    <= MD_NONE;
      sign_a_r   <= 1'b0;
      sign_b_r   <= 1'b0;
      div_zero_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      hi_r       <= 32'd0;
      lo_r       <= 32'd0;
    end else if (clear) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start && (funct != MD_NONE)) begin
            state_r    <= CALC;
            busy_r     <= 1'b1;
            count_r    <= '1;
            funct_r    <= funct;
            sign_a_r   <= md_is_signed(funct) & rs[31];
            sign_b_r   <= md_is_signed(funct) & rt[31];
            div_zero_r <= (rt == 32'd0);
            acc_r      <= {hi_in, lo_in};
            // Divide iterates over the dividend; multiply over the multiplier.
            if (md_is_div(funct)) begin
              work_r <= {32'd0, rs_mag_s};
              opnd_r <= rt_mag_s;
            end else begin
              work_r <= {32'd0, rt_mag_s};
              opnd_r <= rs_mag_s;
            end
          end
        end
        CALC: begin
          work_r <= step_s;
          if (count_r == '0) begin
            state_r <= FIXUP;
          end else begin
            count_r <= count_r - 1'b1;
          end
        end
        FIXUP: begin
          hi_r    <= fix_hi_s;
          lo_r    <= fix_lo_s;
          busy_r  <= 1'b0;
          done_r  <= 1'b1;
          state_r <= DONE;
        end
        DONE: begin
          if (!hold_result) begin
            state_r <= IDLE;
            done_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign hi_out = hi_r;
  assign lo_out = lo_r;

endmodule

// File: tb/tb_muldiv_iterative_unit.sv
// Directed self-checking bench for muldiv_iterative_unit.
module tb_muldiv_iterative_unit;
  import selector::*;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  muldiv_funct_t funct;
  logic [31:0]   rs, rt, hi_in, lo_in;
  logic          clear, hold_result;
  logic          busy, done;
  logic [31:0]   hi_out, lo_out;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  muldiv_iterative_unit dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .funct       (funct),
    .rs          (rs),
    .rt          (rt),
    .hi_in       (hi_in),
    .lo_in       (lo_in),
    .clear       (clear),
    .hold_result (hold_result),
    .busy        (busy),
    .done        (done),
    .hi_out      (hi_out),
    .lo_out      (lo_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and wait (bounded) for done; reports busy cycles and latency.
  task automatic run_op(input muldiv_funct_t f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] h, input logic [31:0] l,
                        output int busy_cnt, output int cyc);
    if (done === 1'b1) tick();
    funct = f; rs = a; rt = b; hi_in = h; lo_in = l; start = 1'b1;
    tick();
    start = 1'b0; funct = MD_NONE;
    busy_cnt = 0; cyc = 0;
    while (done !== 1'b1 && cyc < 100) begin
      if (busy === 1'b1) busy_cnt++;
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    #12;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (hi_out !== 32'd0) begin failures++; $display("FAIL reset_hi got=%h exp=0", hi_out); end
    checks++; if (lo_out !== 32'd0) begin failures++; $display("FAIL reset_lo got=%h exp=0", lo_out); end
    tick();
    reset = 1'b1;
    tick();
    funct = MD_NONE; start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL none_ignored got=%b exp=0", busy); end
  endtask

  task automatic test_mult();
    int nb, nc;
    run_op(MD_MULT, 32'hFFFF_FFFE, 32'd7, 32'd0, 32'd0, nb, nc);
    checks++; if (nb != 33) begin failures++; $display("FAIL mult_busy_cycles got=%0d exp=33", nb); end
    checks++; if (nc != 33) begin failures++; $display("FAIL mult_latency got=%0d exp=33", nc); end
    checks++; if (hi_out !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mult_hi got=%h exp=ffffffff", hi_out); end
    checks++; if (lo_out !== 32'hFFFF_FFF2) begin failures++; $display("FAIL mult_lo got=%h exp=fffffff2", lo_out); end
    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, nb, nc);
    checks++; if (hi_out !== 32'hFFFF_FFFE) begin failures++; $display("FAIL multu_hi got=%h exp=fffffffe", hi_out); end
    checks++; if (lo_out !== 32'h0000_0001) begin failures++; $display("FAIL multu_lo got=%h exp=00000001", lo_out); end
  endtask

  task automatic test_div();
    int nb, nc;
    run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, nb, nc);
    checks++; if (hi_out !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div_hi got=%h exp=ffffffff", hi_out); end
    checks++; if (lo_out !== 32'hFFFF_FFFD) begin failures++; $display("FAIL div_lo got=%h exp=fffffffd", lo_out); end
    run_op(MD_DIVU, 32'd100, 32'd0, 32'd0, 32'd0, nb, nc);
    checks++; if (hi_out !== 32'd100) begin failures++; $display("FAIL divu0_hi got=%h exp=00000064", hi_out); end
    checks++; if (lo_out !== 32'hFFFF_FFFF) begin failures++; $display("FAIL divu0_lo got=%h exp=ffffffff", lo_out); end
    run_op(MD_DIV, 32'hFFFF_FFF9, 32'd0, 32'd0, 32'd0, nb, nc);
    checks++; if (hi_out !== 32'hFFFF_FFF9) begin failures++; $display("FAIL div0_hi got=%h exp=fffffff9", hi_out); end
    checks++; if (lo_out !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div0_lo got=%h exp=ffffffff", lo_out); end
    run_op(MD_DIVU, 32'd100, 32'd7, 32'd0, 32'd0, nb, nc);
    checks++; if (hi_out !== 32'd2) begin failures++; $display("FAIL divu_hi got=%h exp=00000002", hi_out); end
    checks++; if (lo_out !== 32'd14) begin failures++; $display("FAIL divu_lo got=%h exp=0000000e", lo_out); end
  endtask

  task automatic test_acc();
    int nb, nc;
    run_op(MD_MADDU, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF, nb, nc);
    checks++; if (hi_out !== 32'd1) begin failures++; $display("FAIL maddu_hi got=%h exp=00000001", hi_out); end
    checks++; if (lo_out !== 32'd0) begin failures++; $display("FAIL maddu_lo got=%h exp=00000000", lo_out); end
    run_op(MD_MSUB, 32'd1, 32'd1, 32'd0, 32'd0, nb, nc);
    checks++; if (hi_out !== 32'hFFFF_FFFF) begin failures++; $display("FAIL msub_hi got=%h exp=ffffffff", hi_out); end
    checks++; if (lo_out !== 32'hFFFF_FFFF) begin failures++; $display("FAIL msub_lo got=%h exp=ffffffff", lo_out); end
    run_op(MD_MADD, 32'hFFFF_FFFE, 32'd3, 32'd0, 32'd5, nb, nc);
    checks++; if ({hi_out, lo_out} !== 64'hFFFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL madd_res got=%h_%h exp=ffffffff_ffffffff", hi_out, lo_out); end
    run_op(MD_MSUBU, 32'd3, 32'd4, 32'd0, 32'd10, nb, nc);
    checks++; if ({hi_out, lo_out} !== 64'hFFFF_FFFF_FFFF_FFFE) begin failures++; $display("FAIL msubu_res got=%h_%h exp=ffffffff_fffffffe", hi_out, lo_out); end
  endtask

  task automatic test_clear();
    int nb, nc;
    logic seen;
    if (done === 1'b1) tick();
    funct = MD_DIV; rs = 32'd1000; rt = 32'd3; start = 1'b1;
    tick();
    start = 1'b0; funct = MD_NONE;
    repeat (10) tick();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL clear_pre_busy got=%b exp=1", busy); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL clear_busy got=%b exp=0", busy); end
    checks++; if ({hi_out, lo_out} !== 64'hFFFF_FFFF_FFFF_FFFE) begin failures++; $display("FAIL clear_keep got=%h_%h exp=ffffffff_fffffffe", hi_out, lo_out); end
    seen = 1'b0;
    repeat (40) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL clear_no_done got=%b exp=0", seen); end
    run_op(MD_MULT, 32'd3, 32'd3, 32'd0, 32'd0, nb, nc);
    checks++; if (nc != 33) begin failures++; $display("FAIL post_clear_latency got=%0d exp=33", nc); end
    checks++; if ({hi_out, lo_out} !== 64'd9) begin failures++; $display("FAIL post_clear_mult got=%h_%h exp=00000000_00000009", hi_out, lo_out); end
  endtask

  task automatic test_hold();
    int nb, nc;
    if (done === 1'b1) tick();
    hold_result = 1'b1;
    run_op(MD_DIVU, 32'd50, 32'd7, 32'd0, 32'd0, nb, nc);
    checks++; if ({hi_out, lo_out} !== {32'd1, 32'd7}) begin failures++; $display("FAIL hold_res got=%h_%h exp=00000001_00000007", hi_out, lo_out); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (done !== 1'b1 || hi_out !== 32'd1 || lo_out !== 32'd7) begin
        failures++; $display("FAIL hold_stable cyc=%0d done=%b got=%h_%h exp=1 00000001_00000007", i, done, hi_out, lo_out);
      end
    end
    hold_result = 1'b0;
    funct = MD_MULTU; rs = 32'd2; rt = 32'd3; start = 1'b1;
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL release_idle got=done%b busy%b exp=0 0", done, busy); end
    tick();
    start = 1'b0; funct = MD_NONE;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL restart_busy got=%b exp=1", busy); end
    nc = 0;
    while (done !== 1'b1 && nc < 100) begin tick(); nc++; end
    checks++; if (nc != 33) begin failures++; $display("FAIL restart_latency got=%0d exp=33", nc); end
    checks++; if ({hi_out, lo_out} !== 64'd6) begin failures++; $display("FAIL restart_res got=%h_%h exp=00000000_00000006", hi_out, lo_out); end
  endtask

  task automatic test_async_reset();
    int nb, nc;
    if (done === 1'b1) tick();
    funct = MD_MULT; rs = 32'd5; rt = 32'd6; start = 1'b1;
    tick();
    start = 1'b0; funct = MD_NONE;
    repeat (5) tick();
    #2 reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL areset_flags got=busy%b done%b exp=0 0", busy, done); end
    checks++; if ({hi_out, lo_out} !== 64'd0) begin failures++; $display("FAIL areset_out got=%h_%h exp=0_0", hi_out, lo_out); end
    #1 reset = 1'b1;
    tick();
    run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, nb, nc);
    checks++; if (lo_out !== 32'h8000_0000) begin failures++; $display("FAIL divmin_lo got=%h exp=80000000", lo_out); end
    checks++; if (hi_out !== 32'd0) begin failures++; $display("FAIL divmin_hi got=%h exp=00000000", hi_out); end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; funct = MD_NONE; rs = 32'd0; rt = 32'd0;
    hi_in = 32'd0; lo_in = 32'd0; clear = 1'b0; hold_result = 1'b0;
    test_reset();
    test_mult();
    test_div();
    test_acc();
    test_clear();
    test_hold();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
